// File: rtl/input_flit_buffer_if.sv
// Link-side and router-side signals of one input flit buffer.
// The master modport is the buffer itself; the slave modport is its environment.
interface input_flit_buffer_if #(
  parameter int DATA_W = 8,
  parameter int PTR_W  = 2
);
  // Link handshake: a flit transfers on a clk edge where in_valid & in_ready.
  // Router handshake: the head flit is consumed on a clk edge where pop & head_valid.
  logic [DATA_W-1:0] in_flit;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] head_flit;
  logic              head_valid;
  logic              pop;
  logic              credit_out;
  logic [PTR_W:0]    count;
  logic              overflow;

  modport master (
    input  in_flit, in_valid, pop,
    output in_ready, head_flit, head_valid, credit_out, count, overflow
  );

  modport slave (
    output in_flit, in_valid, pop,
    input  in_ready, head_flit, head_valid, credit_out, count, overflow
  );
endinterface

// File: rtl/input_flit_buffer.sv
// Per-port input flit FIFO feeding route compute and the crossbar.
// Returns one credit per dequeued flit; flags flits pushed while full.
module input_flit_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2
) (
  input logic                  clk,
  input logic                  rst,
  input_flit_buffer_if.master  bus
);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic              credit_q, credit_d;
  logic              overflow_q, overflow_d;
  logic              push, do_pop, in_ready, head_valid;

  // Ready depends only on registered occupancy so upstream never sees a pop-dependent path.
  assign in_ready   = (count_q != FULL_CNT);
  assign head_valid = (count_q != '0);
  assign push       = bus.in_valid & in_ready;
  assign do_pop     = bus.pop & head_valid;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    credit_d   = 1'b0;
    overflow_d = overflow_q | (bus.in_valid & ~in_ready);
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      credit_d = 1'b1;
    end
    case ({push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      credit_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      credit_q   <= credit_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is deliberately left unreset; stale entries are masked by head_valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= bus.in_flit;
  end

  assign bus.in_ready   = in_ready;
  assign bus.head_valid = head_valid;
  assign bus.head_flit  = head_valid ? mem_q[rd_ptr_q] : '0;
  assign bus.credit_out = credit_q;
  assign bus.count      = count_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_input_flit_buffer.sv
// Directed bench for input_flit_buffer: latency, fill/overflow, wrap, push+pop, async reset.
module tb_input_flit_buffer;
  logic clk;
  logic rst;
  int   total;
  int   bad;
  logic [7:0] exp_q[$];
  logic [7:0] exp_v;

  input_flit_buffer_if #(.DATA_W(8), .PTR_W(2)) bus ();

  input_flit_buffer #(.DATA_W(8), .DEPTH(4), .PTR_W(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one active edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_one(input logic [7:0] v);
    bus.in_flit  = v;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    exp_q.push_back(v);
  endtask

  task automatic pop_one(input string tag);
    exp_v = exp_q.pop_front();
    check({tag, "_head"}, bus.head_flit, exp_v);
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check({tag, "_credit"}, bus.credit_out, 1);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    bus.in_flit  = 8'h00;
    bus.in_valid = 1'b0;
    bus.pop      = 1'b0;
    #3;
    check("rst_head_valid", bus.head_valid, 0);
    check("rst_head_flit",  bus.head_flit,  0);
    check("rst_count",      bus.count,      0);
    check("rst_in_ready",   bus.in_ready,   1);
    check("rst_credit",     bus.credit_out, 0);
    check("rst_overflow",   bus.overflow,   0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // pop on empty is ignored
    bus.pop = 1'b1;
    tick();
    bus.pop = 1'b0;
    check("empty_pop_count",  bus.count,      0);
    check("empty_pop_credit", bus.credit_out, 0);

    // single flit latency
    push_one(8'hA5);
    check("lat_head_valid", bus.head_valid, 1);
    check("lat_head_flit",  bus.head_flit,  8'hA5);
    check("lat_count",      bus.count,      1);
    tick();
    check("lat_hold_flit",  bus.head_flit,  8'hA5);
    pop_one("lat_pop");
    check("lat_pop_count",  bus.count,      0);
    check("lat_pop_hv",     bus.head_valid, 0);
    check("lat_pop_zero",   bus.head_flit,  0);
    tick();
    check("lat_credit_off", bus.credit_out, 0);

    // fill and overflow; head must stay on 0x11 during pushes
    push_one(8'h11);
    push_one(8'h22);
    check("fill_head_stable", bus.head_flit, 8'h11);
    push_one(8'h33);
    push_one(8'h44);
    check("full_count",    bus.count,    4);
    check("full_in_ready", bus.in_ready, 0);
    check("full_overflow0", bus.overflow, 0);
    bus.in_flit  = 8'h55;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    check("ovf_flag",  bus.overflow,  1);
    check("ovf_count", bus.count,     4);
    check("ovf_head",  bus.head_flit, 8'h11);
    for (int i = 0; i < 4; i++) pop_one("drain");
    tick();
    check("drain_count",   bus.count,      0);
    check("drain_credit0", bus.credit_out, 0);
    check("ovf_sticky",    bus.overflow,   1);

    // push+pop when full: only pop
    push_one(8'hC1);
    push_one(8'hC2);
    push_one(8'hC3);
    push_one(8'hC4);
    exp_v = exp_q.pop_front();
    check("fullpp_head", bus.head_flit, exp_v);
    bus.in_flit  = 8'h66;
    bus.in_valid = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.pop      = 1'b0;
    check("fullpp_count",  bus.count,      3);
    check("fullpp_credit", bus.credit_out, 1);
    check("fullpp_next",   bus.head_flit,  8'hC2);
    for (int i = 0; i < 3; i++) pop_one("fullpp_drain");

    // push+pop when empty: only push
    tick();
    bus.in_flit  = 8'h77;
    bus.in_valid = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.pop      = 1'b0;
    exp_q.push_back(8'h77);
    check("emptypp_count",  bus.count,      1);
    check("emptypp_credit", bus.credit_out, 0);
    check("emptypp_head",   bus.head_flit,  8'h77);

    // push+pop at count=2: count holds, one credit
    push_one(8'h78);
    exp_v = exp_q.pop_front();
    check("midpp_head", bus.head_flit, exp_v);
    bus.in_flit  = 8'h79;
    bus.in_valid = 1'b1;
    bus.pop      = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    bus.pop      = 1'b0;
    exp_q.push_back(8'h79);
    check("midpp_count",  bus.count,      2);
    check("midpp_credit", bus.credit_out, 1);
    for (int i = 0; i < 2; i++) pop_one("midpp_drain");
    tick();

    // wrap-around with occupancy held at 2
    push_one(8'h01);
    push_one(8'h02);
    for (int i = 3; i <= 10; i++) begin
      exp_v = exp_q.pop_front();
      check("wrap_head", bus.head_flit, exp_v);
      bus.in_flit  = 8'(i);
      bus.in_valid = 1'b1;
      bus.pop      = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      bus.pop      = 1'b0;
      exp_q.push_back(8'(i));
      check("wrap_count",  bus.count,      2);
      check("wrap_credit", bus.credit_out, 1);
    end
    pop_one("wrap_tail");
    pop_one("wrap_tail");
    check("wrap_done_count", bus.count, 0);
    tick();

    // async reset mid-stream between edges
    push_one(8'hD1);
    push_one(8'hD2);
    push_one(8'hD3);
    check("pre_rst_count", bus.count, 3);
    exp_q.delete();
    #2 rst = 1'b1;
    #1;
    check("arst_count",      bus.count,      0);
    check("arst_head_valid", bus.head_valid, 0);
    check("arst_head_flit",  bus.head_flit,  0);
    check("arst_in_ready",   bus.in_ready,   1);
    check("arst_overflow",   bus.overflow,   0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("post_rst_credit", bus.credit_out, 0);
      check("post_rst_count",  bus.count,      0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
